// File: rtl/vx_writeback_arb.sv
// Writeback arbiter: merges the per-unit commit streams (ALU, LD, CSR, GPU)
// into the single register-file writeback port. Writing commits are granted
// round-robin into a registered main+skid output stage; commits that do not
// write a register are retired in place and never reach the output.
module vx_writeback_arb #(
    parameter int NUM_REQS    = 4,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               cmt_valid,
    output logic [NUM_REQS-1:0]               cmt_ready,
    input  logic [NUM_REQS*NW_BITS-1:0]       cmt_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0]   cmt_tmask,
    input  logic [NUM_REQS*32-1:0]            cmt_pc,
    input  logic [NUM_REQS*NR_BITS-1:0]       cmt_rd,
    input  logic [NUM_REQS-1:0]               cmt_wb,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0] cmt_data,
    input  logic [NUM_REQS-1:0]               cmt_eop,
    output logic                              wb_valid,
    input  logic                              wb_ready,
    output logic [NW_BITS-1:0]                wb_wid,
    output logic [NUM_THREADS-1:0]            wb_tmask,
    output logic [31:0]                       wb_pc,
    output logic [NR_BITS-1:0]                wb_rd,
    output logic [NUM_THREADS*32-1:0]         wb_data,
    output logic                              wb_eop,
    output logic [31:0]                       wb_count
);

    localparam int RR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam logic [RR_W:0]   NUM_REQS_W = (RR_W+1)'(NUM_REQS);
    localparam logic [RR_W-1:0] LAST_IDX   = RR_W'(NUM_REQS - 1);

    typedef struct packed {
        logic [NW_BITS-1:0]        wid;
        logic [NUM_THREADS-1:0]    tmask;
        logic [31:0]               pc;
        logic [NR_BITS-1:0]        rd;
        logic [NUM_THREADS*32-1:0] data;
        logic                      eop;
    } wb_entry_t;

    logic [RR_W-1:0]     rr_q, rr_d;
    logic                main_valid_q, main_valid_d;
    wb_entry_t           main_q, main_d;
    logic                skid_valid_q, skid_valid_d;
    wb_entry_t           skid_q, skid_d;
    logic [31:0]         wb_count_q, wb_count_d;

    logic [NUM_REQS-1:0] cand;
    logic                can_accept;
    logic                grant_valid;
    logic [RR_W-1:0]     grant_idx;
    wb_entry_t           new_entry;
    logic                drain;

    // Only the skid register gates acceptance, so wb_ready never reaches cmt_ready.
    assign can_accept = !skid_valid_q;
    assign drain      = main_valid_q & wb_ready;

    // Round-robin pick: first writing candidate at or after the pointer.
    always_comb begin
        logic [RR_W:0]   sum;
        logic [RR_W-1:0] idx;
        logic            found;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sum       = '0;
        idx       = '0;
        found     = 1'b0;
        grant_idx = '0;
        cand      = cmt_valid & cmt_wb;
        for (int off = 0; off < NUM_REQS; off++) begin
            sum = {1'b0, rr_q} + (RR_W+1)'(off);
            if (sum >= NUM_REQS_W) begin
                sum = sum - NUM_REQS_W;
            end
            idx = sum[RR_W-1:0];
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!found && (idx == RR_W'(i)) && cand[i]) begin
                    found     = 1'b1;
                    grant_idx = idx;
                end
            end
        end
        grant_valid = found & can_accept;
    end

    // Payload mux for the granted input.
    always_comb begin
        new_entry = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_idx == RR_W'(i)) begin
                new_entry.wid   = cmt_wid[i*NW_BITS +: NW_BITS];
                new_entry.tmask = cmt_tmask[i*NUM_THREADS +: NUM_THREADS];
                new_entry.pc    = cmt_pc[i*32 +: 32];
                new_entry.rd    = cmt_rd[i*NR_BITS +: NR_BITS];
                new_entry.data  = cmt_data[i*NUM_THREADS*32 +: NUM_THREADS*32];
                new_entry.eop   = cmt_eop[i];
            end
        end
    end

    // Per-input accept: non-writing commits always retire, writers only when granted.
    always_comb begin
        cmt_ready = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cmt_ready[i] = reset & ((cmt_valid[i] & ~cmt_wb[i])
                                  | (grant_valid & (grant_idx == RR_W'(i))));
        end
    end

    // Pointer advances past the winner on every grant.
    always_comb begin
        rr_d = rr_q;
        if (grant_valid) begin
            rr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + RR_W'(1);
        end
    end

    // Main/skid next state: skid refills main on a drain, new grants fill main first.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        wb_count_d   = wb_count_q;
        if (drain) begin
            wb_count_d = wb_count_q + 32'd1;
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (grant_valid) begin
                main_d = new_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (grant_valid) begin
            if (!main_valid_q) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end
    end

    // State registers; reset drops any buffered entry and clears the visible outputs.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: payload registers are reset too because the outputs must read zero out of reset.
        if (!reset) begin
            rr_q         <= '0;
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            wb_count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            rr_q         <= rr_d;
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign wb_valid = main_valid_q;
    assign wb_wid   = main_q.wid;
    assign wb_tmask = main_q.tmask;
    assign wb_pc    = main_q.pc;
    assign wb_rd    = main_q.rd;
    assign wb_data  = main_q.data;
    assign wb_eop   = main_q.eop;
    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Bench for vx_writeback_arb: per-input source queues feed the commit ports,
// expected writebacks are pushed in hand-derived grant order, and a monitor
// pops and compares on every writeback handshake.
module tb_vx_writeback_arb;

    typedef struct packed {
        logic         wb;
        logic [1:0]   wid;
        logic [3:0]   tmask;
        logic [31:0]  pc;
        logic [4:0]   rd;
        logic [127:0] data;
        logic         eop;
    } cmt_t;

    logic         clk;
    logic         reset;
    logic [3:0]   cmt_valid;
    logic [3:0]   cmt_ready;
    logic [7:0]   cmt_wid;
    logic [15:0]  cmt_tmask;
    logic [127:0] cmt_pc;
    logic [19:0]  cmt_rd;
    logic [3:0]   cmt_wb;
    logic [511:0] cmt_data;
    logic [3:0]   cmt_eop;
    logic         wb_valid;
    logic         wb_ready;
    logic [1:0]   wb_wid;
    logic [3:0]   wb_tmask;
    logic [31:0]  wb_pc;
    logic [4:0]   wb_rd;
    logic [127:0] wb_data;
    logic         wb_eop;
    logic [31:0]  wb_count;

    int   total = 0;
    int   bad   = 0;
    bit   rand_mode = 1'b0;
    cmt_t src_q[4][$];
    cmt_t exp_q[$];

    vx_writeback_arb dut (
        .clk       (clk),
        .reset     (reset),
        .cmt_valid (cmt_valid),
        .cmt_ready (cmt_ready),
        .cmt_wid   (cmt_wid),
        .cmt_tmask (cmt_tmask),
        .cmt_pc    (cmt_pc),
        .cmt_rd    (cmt_rd),
        .cmt_wb    (cmt_wb),
        .cmt_data  (cmt_data),
        .cmt_eop   (cmt_eop),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_wid    (wb_wid),
        .wb_tmask  (wb_tmask),
        .wb_pc     (wb_pc),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_eop    (wb_eop),
        .wb_count  (wb_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cmt_t mk(input logic wb, input logic [1:0] wid, input logic [3:0] tmask,
                                input logic [31:0] pc, input logic [4:0] rd,
                                input logic [127:0] data, input logic eop);
        cmt_t c;
        c.wb = wb; c.wid = wid; c.tmask = tmask; c.pc = pc;
        c.rd = rd; c.data = data; c.eop = eop;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Driver: presents the head of each source queue, pops it once accepted.
    initial begin
        logic [3:0] acc;
        cmt_t       f;
        cmt_valid = '0; cmt_wid = '0; cmt_tmask = '0; cmt_pc = '0;
        cmt_rd = '0; cmt_wb = '0; cmt_data = '0; cmt_eop = '0;
        forever begin
            @(negedge clk);
            acc = cmt_valid & cmt_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            if (rand_mode) begin
                cmt_valid = 4'($urandom);
                cmt_wb    = 4'($urandom);
                cmt_wid   = 8'($urandom);
                cmt_tmask = 16'($urandom);
                cmt_rd    = 20'($urandom);
                cmt_eop   = 4'($urandom);
                for (int w = 0; w < 4; w++)  cmt_pc[w*32 +: 32]   = $urandom;
                for (int w = 0; w < 16; w++) cmt_data[w*32 +: 32] = $urandom;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    f = (src_q[i].size() > 0) ? src_q[i][0] : '0;
                    cmt_valid[i]           = (src_q[i].size() > 0);
                    cmt_wb[i]              = f.wb;
                    cmt_wid[i*2 +: 2]      = f.wid;
                    cmt_tmask[i*4 +: 4]    = f.tmask;
                    cmt_pc[i*32 +: 32]     = f.pc;
                    cmt_rd[i*5 +: 5]       = f.rd;
                    cmt_data[i*128 +: 128] = f.data;
                    cmt_eop[i]             = f.eop;
                end
            end
        end
    end

    // Monitor: every writeback handshake must match the next expected entry.
    initial begin
        cmt_t e;
        cmt_t a;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
                a = mk(1'b1, wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_eop);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wb_unexpected: got pc %0h expected no writeback", wb_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_payload", 256'(a), 256'(e));
                end
            end
        end
    end

    initial begin
        cmt_t       p;
        cmt_t       b[4];
        cmt_t       c[2];
        cmt_t       d1, d3;
        int         seq[8];
        logic [3:0] bp_rdy[5];
        logic [3:0] by_rdy[4];
        seq = '{1, 2, 3, 0, 1, 2, 3, 0};
        bp_rdy = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        by_rdy = '{4'b0011, 4'b0011, 4'b0010, 4'b0010};

        // Reset with random inputs
        reset = 1'b0;
        wb_ready = 1'b1;
        rand_mode = 1'b1;
        repeat (3) step();
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_count", wb_count, 0);
        check("rst_cmt_ready", cmt_ready, 0);
        check("rst_wb_pc", wb_pc, 0);
        check("rst_wb_data", wb_data, 0);
        rand_mode = 1'b0;
        step();
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            check("idle_wb_valid", wb_valid, 0);
        end

        // Single ALU commit
        p = mk(1'b1, 2'd1, 4'hF, 32'h0000_0100, 5'd5,
               {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);
        src_q[0].push_back(p);
        exp_q.push_back(p);
        step();
        check("alu_ready_n", cmt_ready, 4'b0001);
        check("alu_wb_valid_n", wb_valid, 0);
        step();
        check("alu_wb_valid_n1", wb_valid, 1);
        check("alu_wb_rd", wb_rd, 5);
        check("alu_wb_data", wb_data, {32'h44, 32'h33, 32'h22, 32'h11});
        check("alu_ready_n1", cmt_ready, 0);
        step();
        check("alu_wb_count", wb_count, 1);
        check("alu_wb_valid_idle", wb_valid, 0);

        // Round-robin: pointer sits at 1 after the ALU grant
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                src_q[i].push_back(mk(1'b1, 2'(i), 4'hF, 32'h1000 + 32'(i) * 32'h100 + 32'(k) * 4,
                                      5'(i * 4 + k), {4{32'hA000 + 32'(i * 16 + k)}}, 1'(k)));
            end
        end
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back(mk(1'b1, 2'(seq[j]), 4'hF,
                               32'h1000 + 32'(seq[j]) * 32'h100 + 32'(j / 4) * 4,
                               5'(seq[j] * 4 + j / 4),
                               {4{32'hA000 + 32'(seq[j] * 16 + j / 4)}}, 1'(j / 4)));
        end
        for (int j = 0; j < 8; j++) begin
            step();
            check("rr_grant", cmt_ready, 4'b0001 << seq[j]);
        end
        step();
        step();
        check("rr_wb_count", wb_count, 9);
        check("rr_all_delivered", exp_q.size(), 0);

        // Backpressure: ALU continuously valid, wb_ready low
        wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b[k] = mk(1'b1, 2'd0, 4'h5, 32'h2000 + 32'(k) * 4, 5'(10 + k),
                      {4{32'hB000 + 32'(k)}}, 1'b1);
            src_q[0].push_back(b[k]);
            exp_q.push_back(b[k]);
        end
        for (int j = 0; j < 5; j++) begin
            step();
            check("bp_ready", cmt_ready, bp_rdy[j]);
            if (j >= 1) check("bp_hold_pc", wb_pc, b[0].pc);
        end
        wb_ready = 1'b1;
        step();
        check("bp_out_b1", wb_pc, b[1].pc);
        check("bp_ready_resume", cmt_ready, 4'b0001);
        step();
        check("bp_out_b2", wb_pc, b[2].pc);
        step();
        check("bp_out_b3", wb_pc, b[3].pc);
        step();
        check("bp_drained", wb_valid, 0);
        check("bp_wb_count", wb_count, 13);
        check("bp_all_delivered", exp_q.size(), 0);

        // Non-writing bypass while the buffer fills and stalls
        wb_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            c[k] = mk(1'b1, 2'd2, 4'h3, 32'h3000 + 32'(k) * 4, 5'(20 + k),
                      {4{32'hC000 + 32'(k)}}, 1'b0);
            src_q[0].push_back(c[k]);
            exp_q.push_back(c[k]);
        end
        for (int k = 0; k < 4; k++) begin
            src_q[1].push_back(mk(1'b0, 2'd3, 4'hF, 32'h5000 + 32'(k) * 4, 5'd7,
                                  {4{32'hD000 + 32'(k)}}, 1'b1));
        end
        for (int j = 0; j < 4; j++) begin
            step();
            check("bypass_ready", cmt_ready, by_rdy[j]);
            if (j >= 2) check("bypass_hold_pc", wb_pc, c[0].pc);
        end
        check("bypass_wb_count", wb_count, 13);

        // Async reset between edges with two entries buffered
        #1;
        reset = 1'b0;
        #1;
        check("areset_wb_valid", wb_valid, 0);
        check("areset_wb_count", wb_count, 0);
        check("areset_cmt_ready", cmt_ready, 0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        wb_ready = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            check("areset_no_stale", wb_valid, 0);
        end
        check("areset_count_after", wb_count, 0);

        // Pointer back at 0: LD wins before GPU; tmask=0 still forwarded
        d1 = mk(1'b1, 2'd1, 4'hA, 32'h6000, 5'd9,  {4{32'hE001}}, 1'b1);
        d3 = mk(1'b1, 2'd3, 4'h0, 32'h6100, 5'd31, {4{32'hE003}}, 1'b0);
        src_q[1].push_back(d1);
        src_q[3].push_back(d3);
        exp_q.push_back(d1);
        exp_q.push_back(d3);
        step();
        check("post_rst_grant_ld", cmt_ready, 4'b0010);
        step();
        check("post_rst_grant_gpu", cmt_ready, 4'b1000);
        check("post_rst_out_ld", wb_pc, d1.pc);
        step();
        check("post_rst_out_gpu", wb_pc, d3.pc);
        check("post_rst_tmask0", wb_tmask, 0);
        step();
        check("post_rst_count", wb_count, 2);
        check("post_rst_delivered", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vx_writeback_arb.md
Name: vx_writeback_arb

Overview:
- Downstream neighbour of the execute stage. Collects the per-unit commit streams (ALU, load, CSR, GPU) and merges them into the single register-file writeback port.
- Arbitration is round-robin across units. Commits that do not write a register are retired in place and never reach the output.
- The output is registered through a 2-entry skid buffer, so writeback ready from the register file never combinationally reaches the execute units.

Parameters:
- NUM_REQS, 4, number of commit inputs (index 0=ALU, 1=LD, 2=CSR, 3=GPU).
- NUM_THREADS, 4, lanes per commit.
- NW_BITS, 2, warp-id width.
- NR_BITS, 5, destination register index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmt_valid  in  NUM_REQS  per-input commit valid
- cmt_ready  out  NUM_REQS  per-input commit accept
- cmt_wid  in  NUM_REQS*NW_BITS  warp id
- cmt_tmask  in  NUM_REQS*NUM_THREADS  thread mask
- cmt_pc  in  NUM_REQS*32  instruction PC
- cmt_rd  in  NUM_REQS*NR_BITS  destination register
- cmt_wb  in  NUM_REQS  1 = writes register file
- cmt_data  in  NUM_REQS*NUM_THREADS*32  per-lane result
- cmt_eop  in  NUM_REQS  last packet of instruction
- wb_valid  out  1  writeback valid
- wb_ready  in  1  register file accept
- wb_wid  out  NW_BITS
- wb_tmask  out  NUM_THREADS
- wb_pc  out  32
- wb_rd  out  NR_BITS
- wb_data  out  NUM_THREADS*32
- wb_eop  out  1
- wb_count  out  32  total writebacks delivered (wb_valid & wb_ready), wraps

Behaviour:
- Reset (reset=0, async):
  - wb_valid=0, skid entry invalid, all wb_* data outputs = 0, wb_count=0, rr pointer=0.
  - cmt_ready=0 while reset is asserted.
  - Reset mid-transfer discards any buffered entry.
- Non-writing commits: an input with cmt_valid=1 and cmt_wb=0 gets cmt_ready=1 in the same cycle, unconditionally. It is not arbitrated and not forwarded.
- Candidates: inputs with cmt_valid=1 and cmt_wb=1.
- Grant:
  - The first candidate at or after rr pointer (mod NUM_REQS) wins.
  - The grant is issued only when can_accept=1, where can_accept = !skid_valid.
  - cmt_ready[i]=1 only for the granted i; other candidates are held at ready=0 and must hold their data stable.
- Pointer update: on each grant, rr pointer = (granted index + 1) mod NUM_REQS. No grant leaves the pointer unchanged.
- Output stage (main register + skid register):
  - Accepted entry goes to the main register if the main register is empty or is draining this cycle (wb_valid & wb_ready); otherwise it goes to skid.
  - When main drains and skid is valid, skid moves to main in that cycle.
  - A simultaneous drain and new accept with skid empty loads main directly.
- Latency: a commit accepted in cycle N appears on wb_* in cycle N+1, absent backpressure.
- Stall: wb_valid & !wb_ready holds all wb_* stable. At most one more entry is accepted (into skid); then cmt_ready drops for writing inputs.
- Throughput: one writeback per cycle under sustained wb_ready=1.
- wb_count increments by 1 on each wb_valid & wb_ready handshake and wraps 0xFFFFFFFF→0.
- Ordering: per-input commit order is preserved. Cross-input order follows grant order.
- Payload (wid, tmask, pc, rd, data, eop) is copied unchanged. tmask=0 with wb=1 is still forwarded.

Test Plan:
- Reset and idle: reset=0 with random inputs → wb_valid=0, wb_count=0, cmt_ready=0; after reset=1 with no valid inputs → wb_valid stays 0.
- Single ALU commit: cmt_valid=0001, wb=1, rd=5, data lanes 0x11/0x22/0x33/0x44 in cycle N → cmt_ready=0001 at N, wb_valid=1 with the same payload at N+1, wb_count=1 after the handshake.
- Round-robin fairness: all four inputs valid with wb=1 continuously, wb_ready=1 → grants ALU,LD,CSR,GPU,ALU,... one per cycle; 8 writebacks in 8 cycles.
- Backpressure: wb_ready=0 for 5 cycles with ALU continuously valid → exactly 2 commits accepted (main + skid), then cmt_ready=0. On wb_ready=1, the two commits emerge on consecutive cycles in order.
- Non-writing bypass: LD input valid with wb=0 while wb_ready=0 and the buffer is full → cmt_ready[1]=1 every cycle, no wb_valid generated, wb_count unchanged.
- Async reset mid-stall: buffer holding 2 entries, reset pulses low between clock edges → wb_valid=0 immediately; after release the old entries never appear.
